multicycle_control_unit: RTL

//  Moore/Mealy FSM control for the multi-cycle MIPS datapath; successor to the single-cycle opcode decoder.

---
 rtl/multicycle_control_unit_pkg.sv | 57 +++++
 rtl/multicycle_control_unit_op_decode.sv | 31 +++
 rtl/multicycle_control_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state encoding,
// opcode values, ALU operation codes and datapath mux select codes.
package multicycle_control_unit_pkg;

  // Controller states; encodings 13..15 are unused and recover to S_FETCH.
  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  // Supported opcodes (IR[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operation requests.
  localparam logic [2:0] ALUOP_RTYPE = 3'b000;
  localparam logic [2:0] ALUOP_ADD   = 3'b001;
  localparam logic [2:0] ALUOP_SUB   = 3'b010;

  // ALU B operand select.
  localparam logic [1:0] ALUSRCB_RT     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

  // Next-PC select.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // One-hot instruction class produced by the opcode decoder.
  typedef struct packed {
    logic rtype;
    logic lw;
    logic sw;
    logic beq;
    logic addi;
    logic j;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/multicycle_control_unit_op_decode.sv
// Opcode classifier: maps the IR opcode to a one-hot instruction class.
module multicycle_control_unit_op_decode
  import multicycle_control_unit_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] op,
  output op_class_t       op_class
);

  // Classify the opcode; anything not recognised is flagged illegal.
  always_comb begin
    op_class = '0;
    if (op == OP_W'(OP_RTYPE)) begin
      op_class.rtype = 1'b1;
    end else if (op == OP_W'(OP_LW)) begin
      op_class.lw = 1'b1;
    end else if (op == OP_W'(OP_SW)) begin
      op_class.sw = 1'b1;
    end else if (op == OP_W'(OP_BEQ)) begin
      op_class.beq = 1'b1;
    end else if (op == OP_W'(OP_ADDI)) begin
      op_class.addi = 1'b1;
    end else if (op == OP_W'(OP_J)) begin
      op_class.j = 1'b1;
    end else begin
      op_class.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/
// write-back for R-type, lw, sw, beq, addi and j, stalling on mem_ready.
// Outputs are decoded from the current state (Moore) plus mem_ready/zero
// in the states that need a same-cycle response (Mealy).
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int ST_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemToReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         PCSrc,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [ST_W-1:0]    state
);

  state_t     state_r;
  state_t     state_next;
  op_class_t  op_class;
  logic [2:0] alu_op;

  multicycle_control_unit_op_decode #(
    .OP_W (OP_W)
  ) u_op_decode (
    .op       (op),
    .op_class (op_class)
  );

  assign ALUOp = ALUOP_W'(alu_op);
  assign state = ST_W'(state_r);

  // State register; reset forces S_RESET immediately, which zeroes every output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_RESET;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state selection and datapath control decode for the current state.
  always_comb begin
    state_next = S_FETCH;
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemToReg   = 1'b0;
    RegDst     = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = ALUSRCB_RT;
    alu_op     = ALUOP_RTYPE;
    PCSrc      = PCSRC_ALU;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state_r)
      S_RESET: begin
        state_next = S_FETCH;
      end
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = ALUSRCB_FOUR;
        alu_op  = ALUOP_ADD;
        PCSrc   = PCSRC_ALU;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = S_DECODE;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while the opcode is decoded.
        ALUSrcB = ALUSRCB_IMM_SH;
        alu_op  = ALUOP_ADD;
        if (op_class.rtype) begin
          state_next = S_EXEC;
        end else if (op_class.lw || op_class.sw) begin
          state_next = S_MEMADR;
        end else if (op_class.beq) begin
          state_next = S_BRANCH;
        end else if (op_class.addi) begin
          state_next = S_ADDIEX;
        end else if (op_class.j) begin
          state_next = S_JUMP;
        end else if (op_class.illegal) begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ALUSRCB_IMM;
        alu_op  = ALUOP_ADD;
        if (op_class.sw) begin
          state_next = S_MEMWR;
        end else begin
          state_next = S_MEMRD;
        end
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          state_next = S_MEMWB;
        end else begin
          state_next = S_MEMRD;
        end
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemToReg   = 1'b1;
        RegDst     = 1'b0;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_MEMWR;
        end
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = ALUSRCB_RT;
        alu_op     = ALUOP_RTYPE;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = ALUSRCB_IMM;
        alu_op     = ALUOP_ADD;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b0;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = ALUSRCB_RT;
        alu_op     = ALUOP_SUB;
        PCSrc      = PCSRC_ALUOUT;
        PCWrite    = zero;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        PCSrc      = PCSRC_JUMP;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      default: begin
        // Unused encodings: all outputs stay 0 and the FSM recovers to fetch.
        state_next = S_FETCH;
      end
    endcase
  end

endmodule
